// File: rtl/arvi_pkg.sv
// arvi_pkg: shared definitions for the branch resolve controller.
//   br_state_e  - controller FSM states
//   F3_*        - branch funct3 encodings
//   f3_legal()  - true for the six defined branch funct3 codes
package arvi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT     = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_FLUSH    = 3'd4
  } br_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) ||
           (f3 == F3_BGE) || (f3 == F3_BLTU) || (f3 == F3_BGEU);
  endfunction

endpackage

// File: rtl/branch_control.sv
// branch_control: combinational branch outcome from ALU flags.
//   i_Branch - qualifies the decision; taken is 0 when low
//   i_f3     - branch funct3
//   i_z      - ALU zero flag (operands equal)
//   i_res    - ALU less-than result (signed or unsigned per f3)
//   o_taken  - branch taken
module branch_control
  import arvi_pkg::*;
(
  input  logic       i_Branch,
  input  logic [2:0] i_f3,
  input  logic       i_z,
  input  logic       i_res,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    if (i_Branch) begin
      case (i_f3)
        F3_BEQ:           o_taken = i_z;
        F3_BNE:           o_taken = ~i_z;
        F3_BLT, F3_BLTU:  o_taken = i_res;
        F3_BGE, F3_BGEU:  o_taken = ~i_res;
        default:          o_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: accepts one branch at a time from execute, borrows
// the shared ALU for the compare, checks the outcome against the fetch
// prediction and, on a mispredict, redirects fetch and flushes the pipe.
//   i_clk/i_rst                 - clock, synchronous active-high reset
//   i_br_valid/o_br_ready       - branch handshake (ready only in IDLE)
//   i_br_f3/i_br_pc/i_br_imm    - branch funct3, PC, sign-extended offset
//   i_pred_taken                - fetch prediction for this branch
//   o_alu_req/i_alu_gnt         - shared ALU request/grant
//   i_alu_done/i_alu_z/i_alu_res- ALU result strobe and flags
//   o_redirect/o_redirect_pc    - one-cycle fetch redirect and target
//   o_flush                     - pipeline flush, FLUSH_CYCLES long
//   o_invalid                   - one-cycle pulse for an illegal funct3
//   o_mispredict_cnt            - saturating mispredict counter
// All outputs are registered; they are computed from the next state.
module branch_resolve_ctrl
  import arvi_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_br_valid,
  output logic            o_br_ready,
  input  logic [2:0]      i_br_f3,
  input  logic [XLEN-1:0] i_br_pc,
  input  logic [XLEN-1:0] i_br_imm,
  input  logic            i_pred_taken,
  output logic            o_alu_req,
  input  logic            i_alu_gnt,
  input  logic            i_alu_done,
  input  logic            i_alu_z,
  input  logic            i_alu_res,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic            o_invalid,
  output logic [31:0]     o_mispredict_cnt
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  br_state_e       state, state_n;
  logic [3:0]      flush_cnt, flush_cnt_n;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic            pred_q;
  logic [31:0]     cnt_q;

  logic            hs, hs_legal, hs_illegal;
  logic            taken;
  logic [XLEN-1:0] target;

  assign hs         = i_br_valid & o_br_ready;
  assign hs_legal   = hs & f3_legal(i_br_f3);
  assign hs_illegal = hs & ~f3_legal(i_br_f3);

  branch_control u_bc (
    .i_Branch (f3_legal(f3_q)),
    .i_f3     (f3_q),
    .i_z      (i_alu_z),
    .i_res    (i_alu_res),
    .o_taken  (taken)
  );

  assign target = taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // Next state; ALU flags only matter in WAIT with done high.
  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    case (state)
      ST_IDLE:     if (hs_legal) state_n = ST_REQ;
      ST_REQ:      if (i_alu_gnt) state_n = ST_WAIT;
      ST_WAIT:     if (i_alu_done) state_n = (taken == pred_q) ? ST_IDLE : ST_REDIRECT;
      ST_REDIRECT: begin
        state_n     = ST_FLUSH;
        flush_cnt_n = FLUSH_LAST;
      end
      ST_FLUSH: begin
        if (flush_cnt == 4'd0) state_n = ST_IDLE;
        else                   flush_cnt_n = flush_cnt - 4'd1;
      end
      default:     state_n = ST_IDLE;
    endcase
  end

  // Operand latch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      f3_q   <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
      pred_q <= 1'b0;
    end else if (hs_legal) begin
      f3_q   <= i_br_f3;
      pc_q   <= i_br_pc;
      imm_q  <= i_br_imm;
      pred_q <= i_pred_taken;
    end
  end

  // Registered outputs derived from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_br_ready    <= 1'b1;
      o_alu_req     <= 1'b0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_flush       <= 1'b0;
      o_invalid     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      o_br_ready    <= (state_n == ST_IDLE);
      o_alu_req     <= (state_n == ST_REQ);
      o_redirect    <= (state_n == ST_REDIRECT);
      o_redirect_pc <= (state_n == ST_REDIRECT) ? target : '0;
      o_flush       <= (state_n == ST_FLUSH);
      o_invalid     <= (state == ST_IDLE) && hs_illegal;
      // Only the WAIT->REDIRECT transition enters REDIRECT
      if (state == ST_WAIT && state_n == ST_REDIRECT && cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign o_mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl. Inputs are driven and outputs
// sampled on the falling edge, half a cycle away from the active edge.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_f3;
  logic [31:0] br_pc, br_imm;
  logic        pred_taken;
  logic        alu_req, alu_gnt, alu_done, alu_z, alu_res;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush, invalid;
  logic [31:0] mp_cnt;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_br_valid       (br_valid),
    .o_br_ready       (br_ready),
    .i_br_f3          (br_f3),
    .i_br_pc          (br_pc),
    .i_br_imm         (br_imm),
    .i_pred_taken     (pred_taken),
    .o_alu_req        (alu_req),
    .i_alu_gnt        (alu_gnt),
    .i_alu_done       (alu_done),
    .i_alu_z          (alu_z),
    .i_alu_res        (alu_res),
    .o_redirect       (redirect),
    .o_redirect_pc    (redirect_pc),
    .o_flush          (flush),
    .o_invalid        (invalid),
    .o_mispredict_cnt (mp_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ready, alu_req, redirect, flush, invalid packed for compact checks
  function automatic logic [31:0] ctl();
    return {27'd0, br_ready, alu_req, redirect, flush, invalid};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, ctl(), 32'b10000);
    chk({tag, "_pc"},  redirect_pc, 32'h0);
    chk({tag, "_cnt"}, mp_cnt, 32'h0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    br_valid = 1'b1; br_f3 = f3; br_pc = pc; br_imm = imm; pred_taken = pred;
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_f3 = 3'b000; br_pc = '0; br_imm = '0;
    pred_taken = 1'b0; alu_gnt = 1'b0; alu_done = 1'b0; alu_z = 1'b0; alu_res = 1'b0;
    step();
    chk_reset_vals("reset");
    rst = 1'b0;

    // BEQ, pred 0, z=1 -> mispredict to pc+imm
    issue(3'b000, 32'h100, 32'h40, 1'b0); alu_gnt = 1'b1;
    step();                                   // REQ
    chk("beq_req", ctl(), 32'b01000);
    br_valid = 1'b0;
    step();                                   // WAIT
    chk("beq_wait", ctl(), 32'b00000);
    alu_gnt = 1'b0; alu_done = 1'b1; alu_z = 1'b1;
    step();                                   // REDIRECT
    alu_done = 1'b0; alu_z = 1'b0;
    chk("beq_redir", ctl(), 32'b00100);
    chk("beq_tgt", redirect_pc, 32'h140);
    chk("beq_cnt", mp_cnt, 32'd1);
    step();
    chk("beq_flush1", ctl(), 32'b00010);
    chk("beq_pc0", redirect_pc, 32'h0);
    step();
    chk("beq_flush2", ctl(), 32'b00010);
    step();
    chk("beq_idle", ctl(), 32'b10000);

    // BLT, pred 1, res=1 -> correct prediction, 3-cycle occupancy
    issue(3'b100, 32'h200, 32'h8, 1'b1); alu_gnt = 1'b1;
    step(); br_valid = 1'b0;
    step(); alu_gnt = 1'b0; alu_done = 1'b1; alu_res = 1'b1;
    step(); alu_done = 1'b0; alu_res = 1'b0;
    chk("blt_idle", ctl(), 32'b10000);
    chk("blt_cnt", mp_cnt, 32'd1);
    step();
    chk("blt_quiet", ctl(), 32'b10000);

    // BGEU not taken vs pred 1 -> pc+4 wraps to 0
    issue(3'b111, 32'hFFFF_FFFC, 32'h10, 1'b1); alu_gnt = 1'b1;
    step(); br_valid = 1'b0;
    step(); alu_gnt = 1'b0; alu_done = 1'b1; alu_res = 1'b1;
    step(); alu_done = 1'b0; alu_res = 1'b0;
    chk("bgeu_redir", ctl(), 32'b00100);
    chk("bgeu_tgt", redirect_pc, 32'h0000_0000);
    chk("bgeu_cnt", mp_cnt, 32'd2);
    step(); step(); step();
    chk("bgeu_idle", ctl(), 32'b10000);

    // Illegal f3 = 010
    issue(3'b010, 32'h300, 32'h4, 1'b0);
    step(); br_valid = 1'b0;
    chk("ill_pulse", ctl(), 32'b10001);
    step();
    chk("ill_end", ctl(), 32'b10000);
    chk("ill_cnt", mp_cnt, 32'd2);

    // BNE: grant withheld 5 cycles, spurious done (z=0 -> would be taken) in REQ
    issue(3'b001, 32'h400, 32'h20, 1'b0);
    step(); br_valid = 1'b0;
    alu_done = 1'b1; alu_z = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bne_hold%0d", i), ctl(), 32'b01000);
    end
    alu_done = 1'b0; alu_gnt = 1'b1;
    step();                                   // WAIT
    alu_gnt = 1'b0;
    chk("bne_wait", ctl(), 32'b00000);
    step();                                   // still WAIT, no done
    chk("bne_wait2", ctl(), 32'b00000);
    alu_done = 1'b1; alu_z = 1'b1;            // not taken, matches pred 0
    step(); alu_done = 1'b0; alu_z = 1'b0;
    chk("bne_idle", ctl(), 32'b10000);
    chk("bne_cnt", mp_cnt, 32'd2);

    // Reset during FLUSH
    issue(3'b000, 32'h500, 32'h80, 1'b0); alu_gnt = 1'b1;
    step(); br_valid = 1'b0;
    step(); alu_gnt = 1'b0; alu_done = 1'b1; alu_z = 1'b1;
    step(); alu_done = 1'b0; alu_z = 1'b0;
    chk("rf_cnt3", mp_cnt, 32'd3);
    step();
    chk("rf_inflush", ctl(), 32'b00010);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk_reset_vals("rst_flush");
    step(); step();
    chk("rf_after", ctl(), 32'b10000);

    // Reset during WAIT with done arriving at the same edge
    issue(3'b000, 32'h600, 32'h80, 1'b0); alu_gnt = 1'b1;
    step(); br_valid = 1'b0;
    step(); alu_gnt = 1'b0;
    chk("rw_wait", ctl(), 32'b00000);
    rst = 1'b1; alu_done = 1'b1; alu_z = 1'b1;
    step(); rst = 1'b0; alu_done = 1'b0; alu_z = 1'b0;
    chk_reset_vals("rst_wait");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rw_noredir%0d", i), ctl(), 32'b10000);
    end

    // Saturation: preset counter to all-ones, then one more mispredict
    force dut.cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.cnt_q;
    chk("sat_preset", mp_cnt, 32'hFFFF_FFFF);
    issue(3'b101, 32'h700, 32'h10, 1'b0); alu_gnt = 1'b1;  // BGE, res=0 -> taken
    step(); br_valid = 1'b0;
    step(); alu_gnt = 1'b0; alu_done = 1'b1; alu_res = 1'b0;
    step(); alu_done = 1'b0;
    chk("sat_redir", ctl(), 32'b00100);
    chk("sat_tgt", redirect_pc, 32'h710);
    chk("sat_cnt", mp_cnt, 32'hFFFF_FFFF);
    step(); step(); step();
    chk("sat_idle", ctl(), 32'b10000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
